rng_arbiter: RTL
================

# rng_arbiter

Round-robin arbiter and sequencer that shares one `floatRNG` random-number source among `NUM_REQ` requesters. It issues the RNG `call` strobe on behalf of the winning requester and waits the RNG's fixed latency. It then captures the 16-bit word and returns it to that requester with a one-cycle acknowledge. It sits between the requesting datapath blocks and the single RNG instance, so no requester drives the RNG directly.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2–8.
- `WORD_WIDTH`, 16: RNG data width.
- `RNG_LATENCY`, 1: cycles from the end of the `rng_call` cycle until `rng_data` is valid; legal range 1–15.

Ports:
- `clock`, in, 1: single clock; all logic updates on the rising edge.
- `nreset`, in, 1: synchronous, active-low reset.
- `req`, in, `NUM_REQ`: per-requester request level; held high until the matching `ack` bit pulses.
- `rng_data`, in, `WORD_WIDTH`: the RNG's `data_out`.
- `rng_call`, out, 1: the RNG's `call` input.
- `ack`, out, `NUM_REQ`: one-hot, one-cycle acknowledge; `data_out` is valid in the same cycle.
- `data_out`, out, `WORD_WIDTH`: captured random word.
- `grant_id`, out, `clog2(NUM_REQ)`: index of the current or most recent grant.
- `busy`, out, 1: high in every state except IDLE.

## Operation

- State machine states are IDLE, CALL, WAIT and DELIVER.
- **IDLE**
  - If `req` ≠ 0, pick the winner round-robin and go to CALL.
  - Otherwise stay in IDLE.
- **CALL**
  - `rng_call`=1 for exactly this one cycle.
  - Load the wait counter with `RNG_LATENCY`, then go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, register `data_out` ← `rng_data` and set `ack[grant_id]`, then go to DELIVER.
- **DELIVER**
  - `ack` is one-hot on `grant_id` for this one cycle.
  - Always go to IDLE; back-to-back grants keep one idle cycle between them.
- **Round-robin:**
  - The `last` pointer holds the previous grant.
  - The search starts at `last+1` modulo `NUM_REQ`; the first set `req` bit wins.
  - On reset `last` = `NUM_REQ-1`, so requester 0 has priority first.
  - `last` updates in the IDLE→CALL transition.
- `req` is sampled only in IDLE; changes in other states are ignored.
- Once granted, a transaction always completes. `ack` pulses even if the requester dropped `req` during CALL or WAIT.
- `rng_call` is 0 in every state except CALL, so the RNG sees no spurious strobes.
- `data_out` holds its last captured value until the next capture; it never returns to 0 except on reset.
- `grant_id` updates on IDLE→CALL and holds until the next grant.

## Timing

- **Reset values:** `rng_call`=0, `ack`=0, `data_out`=0, `grant_id`=0, `busy`=0, state IDLE, `last`=`NUM_REQ-1`.
- **Grant latency:** with `req` sampled in IDLE at cycle 0:
  - `rng_call`=1 in cycle 1;
  - WAIT occupies cycles 2 … `RNG_LATENCY`+1;
  - `rng_data` is sampled in cycle `RNG_LATENCY`+1;
  - `ack` and the new `data_out` appear in cycle `RNG_LATENCY`+2;
  - IDLE returns in cycle `RNG_LATENCY`+3.
- **Throughput:** one grant per `RNG_LATENCY`+3 cycles under continuous requests. At default parameters that is one grant every 4 cycles.
- **Reset mid-operation:** `nreset`=0 in any state aborts the transaction.
  - No `ack` is produced.
  - All outputs take reset values on the next edge.
  - Priority restarts at requester 0.
- **Simultaneous requests:** exactly one winner per arbitration, never two `ack` bits in the same cycle.
- **Pointer wrap:** after granting requester `NUM_REQ-1`, the search starts at 0.

## Test plan

1. **Reset values.** Hold `nreset`=0 for 3 cycles with `req`=4'b1111 → `rng_call`=0, `ack`=0, `data_out`=0, `busy`=0 throughout.
2. **Single request.** `req`=4'b0100 at cycle 0, `rng_data`=16'h0001 from cycle 2 →
   - `rng_call`=1 in cycle 1 only;
   - `ack`=4'b0100 with `data_out`=16'h0001 and `grant_id`=2 in cycle 3;
   - `busy` low again in cycle 4.
3. **All requesters, continuous.** `req`=4'b1111 held, acks released per bit →
   - `ack` order 0001, 0010, 0100, 1000, 0001;
   - one `ack` every 4 cycles;
   - never more than one `ack` bit set.
4. **Request dropped after grant.** `req`=4'b0001 for cycle 0 only → `ack`=4'b0001 still pulses in cycle 3.
5. **Reset in WAIT.** `req`=4'b0010 at cycle 0, `nreset`=0 in cycle 2 →
   - no `ack`;
   - all outputs at reset values in cycle 3;
   - after release, `req`=4'b0011 grants requester 0 first.
6. **Longer RNG latency.** With `RNG_LATENCY`=3, `req`=4'b0001 at cycle 0, `rng_data`=16'hABCD valid from cycle 4 →
   - `rng_call`=1 in cycle 1;
   - `ack`=4'b0001 and `data_out`=16'hABCD in cycle 5.

Source files
------------

// File: rtl/rng_arbiter.sv
// ============================================================================
// Module  : rng_arbiter
// Brief   : Round-robin sequencer sharing one RNG among NUM_REQ requesters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rng_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WORD_WIDTH  = 16,
  parameter int RNG_LATENCY = 1
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [WORD_WIDTH-1:0]      rng_data,
  output logic                       rng_call,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WORD_WIDTH-1:0]      data_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = 4;
  localparam logic [ID_W-1:0]  c_last_rst = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(RNG_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CALL    = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_last;
  logic [CNT_W-1:0] r_cnt;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_idx;
  logic [NUM_REQ-1:0] w_onehot;
  int                 w_k;

  // Scan from the slot after the previous grant, wrapping modulo NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    w_k      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_k = int'(r_last) + off;
      if (w_k >= NUM_REQ) begin
        w_k = w_k - NUM_REQ;
      end
      w_idx = ID_W'(w_k);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_onehot           = '0;
    w_onehot[grant_id] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state  <= S_IDLE;
      r_last   <= c_last_rst;
      r_cnt    <= '0;
      rng_call <= 1'b0;
      ack      <= '0;
      data_out <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state  <= S_CALL;
            r_last   <= w_winner;
            grant_id <= w_winner;
            rng_call <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_CALL: begin
          rng_call <= 1'b0;
          r_cnt    <= c_cnt_load;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            data_out <= rng_data;
            ack      <= w_onehot;
            r_state  <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          ack     <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
